// File: rtl/memory_read_arbiter.sv
// Round-robin arbiter sharing one memory read port among several requesters, with a
// bounded burst lock and a one-hot tag pipeline that routes returned data to its owner.
module memory_read_arbiter #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 11,
  parameter int unsigned REQUESTERS    = 4,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned MAX_BURST     = 8
) (
  input  logic                                clock_in,
  input  logic                                reset_in,
  input  logic [REQUESTERS-1:0]               req_in,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]               memory_data_in,
  output logic [REQUESTERS-1:0]               grant_out,
  output logic [ADDRESS_WIDTH-1:0]            memory_address_out,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic [REQUESTERS-1:0]               data_valid_out,
  output logic                                busy_out
);

  localparam int unsigned IdxW   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(REQUESTERS - 1);
  localparam logic [BurstW-1:0] MaxBurst = BurstW'(MAX_BURST);

  logic                     owner_valid_q, owner_valid_d;
  logic [IdxW-1:0]          owner_q, owner_d;
  logic [BurstW-1:0]        burst_q, burst_d;
  logic [REQUESTERS-1:0]    grant_q, grant_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [REQUESTERS-1:0]    valid_q;
  logic [REQUESTERS-1:0]    tag_q [READ_LATENCY];

  logic [REQUESTERS-1:0] others_req;
  logic                  keep_owner;
  logic                  found;
  logic [IdxW-1:0]       pick;
  int unsigned           start_idx;
  int unsigned           idx;

  always_comb begin
    others_req          = req_in;
    others_req[owner_q] = 1'b0;
    // Owner keeps the port while under its burst budget, or indefinitely if nobody else waits.
    keep_owner = owner_valid_q && req_in[owner_q] && ((burst_q < MaxBurst) || (others_req == '0));

    start_idx = 0;
    if (owner_valid_q && (owner_q != LastIdx)) begin
      start_idx = 32'(owner_q) + 1;
    end

    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      idx = (start_idx + i) % REQUESTERS;
      if (!found && req_in[IdxW'(idx)]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end

    grant_d       = '0;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    burst_d       = burst_q;
    if (keep_owner) begin
      grant_d[owner_q] = 1'b1;
      if (burst_q < MaxBurst) begin
        burst_d = burst_q + BurstW'(1);
      end
    end else if (found) begin
      grant_d[pick] = 1'b1;
      owner_d       = pick;
      owner_valid_d = 1'b1;
      burst_d       = BurstW'(1);
    end

    addr_d = addr_q;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      if (grant_d[k]) begin
        addr_d = address_in[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      owner_valid_q <= 1'b0;
      owner_q       <= '0;
      burst_q       <= '0;
      grant_q       <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      valid_q       <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      burst_q       <= burst_d;
      grant_q       <= grant_d;
      addr_q        <= addr_d;
      tag_q[0]      <= grant_d;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      valid_q <= tag_q[READ_LATENCY-1];
      if (|tag_q[READ_LATENCY-1]) begin
        data_q <= memory_data_in;
      end
    end
  end

  logic tag_any;
  always_comb begin
    tag_any = 1'b0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      tag_any = tag_any | (|tag_q[i]);
    end
  end

  assign grant_out          = grant_q;
  assign memory_address_out = addr_q;
  assign data_out           = data_q;
  assign data_valid_out     = valid_q;
  assign busy_out           = (|grant_q) | tag_any;

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed bench for memory_read_arbiter: four instances with READ_LATENCY 1..4 (MAX_BURST 8)
// and one with MAX_BURST 1, all sharing request/address stimulus, each with its own memory model.
module tb_memory_read_arbiter;

  localparam int NDUT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [43:0] addr;

  logic [3:0]  g    [NDUT];
  logic [10:0] ma   [NDUT];
  logic [15:0] dout [NDUT];
  logic [3:0]  dv   [NDUT];
  logic        busy [NDUT];
  logic [15:0] mdin [NDUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [10:0] a);
    return {~a[10:6], a} ^ 16'hF80E;
  endfunction

  // Instances 0..3: READ_LATENCY = index+1, MAX_BURST = 8.
  for (genvar i = 0; i < 4; i++) begin : g_dut
    memory_read_arbiter #(
      .DATA_WIDTH(16), .ADDRESS_WIDTH(11), .REQUESTERS(4), .READ_LATENCY(i + 1), .MAX_BURST(8)
    ) u_dut (
      .clock_in(clk), .reset_in(rst), .req_in(req), .address_in(addr),
      .memory_data_in(mdin[i]), .grant_out(g[i]), .memory_address_out(ma[i]),
      .data_out(dout[i]), .data_valid_out(dv[i]), .busy_out(busy[i])
    );
  end

  memory_read_arbiter #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(11), .REQUESTERS(4), .READ_LATENCY(1), .MAX_BURST(1)
  ) u_mb1 (
    .clock_in(clk), .reset_in(rst), .req_in(req), .address_in(addr),
    .memory_data_in(mdin[4]), .grant_out(g[4]), .memory_address_out(ma[4]),
    .data_out(dout[4]), .data_valid_out(dv[4]), .busy_out(busy[4])
  );

  // Memory data must be stable at the edge READ_LATENCY after the address was registered.
  for (genvar i = 0; i < NDUT; i++) begin : g_mem
    localparam int Lat = (i == 4) ? 1 : i + 1;
    if (Lat == 1) begin : g_comb
      assign mdin[i] = mem_word(ma[i]);
    end else begin : g_pipe
      logic [15:0] pipe [Lat-1];
      always @(posedge clk) begin
        pipe[0] <= mem_word(ma[i]);
        for (int j = 1; j < Lat - 1; j++) pipe[j] <= pipe[j-1];
      end
      assign mdin[i] = pipe[Lat-2];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [10:0] a);
    addr[k*11 +: 11] = a;
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (g[i] !== 4'b0 || ma[i] !== 11'h0 || dout[i] !== 16'h0 || dv[i] !== 4'b0 ||
          busy[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d: got g=%b ma=%h d=%h dv=%b busy=%b expected all zero",
                 i, g[i], ma[i], dout[i], dv[i], busy[i]);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001;
    set_addr(0, 11'h00F);
    tick();
    checks++;
    if (g[0] !== 4'b0001 || ma[0] !== 11'h00F || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: got g=%b ma=%h busy=%b expected 0001 00f 1", g[0], ma[0], busy[0]);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (dv[0] !== 4'b0001 || dout[0] !== 16'h0001 || g[0] !== 4'b0) begin
      failures++;
      $display("FAIL single_data: got dv=%b d=%h g=%b expected 0001 0001 0000", dv[0], dout[0], g[0]);
    end
    tick();
    checks++;
    if (dv[0] !== 4'b0 || dout[0] !== 16'h0001 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_hold: got dv=%b d=%h busy=%b expected 0000 0001 0", dv[0], dout[0], busy[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [3:0] ev;
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) set_addr(k, 11'(11'h100 + k));
    for (int c = 0; c < 9; c++) begin
      tick();
      eg = 4'b0001 << (c % 4);
      checks++;
      if (g[4] !== eg || ma[4] !== 11'(11'h100 + (c % 4))) begin
        failures++;
        $display("FAIL rr_grant c=%0d: got g=%b ma=%h expected %b %h", c, g[4], ma[4], eg,
                 11'(11'h100 + (c % 4)));
      end
      if (c >= 1) begin
        ev = 4'b0001 << ((c - 1) % 4);
        checks++;
        if (dv[4] !== ev || dout[4] !== mem_word(11'(11'h100 + ((c - 1) % 4)))) begin
          failures++;
          $display("FAIL rr_data c=%0d: got dv=%b d=%h expected %b %h", c, dv[4], dout[4], ev,
                   mem_word(11'(11'h100 + ((c - 1) % 4))));
        end
      end
    end
    req = '0;
  endtask

  task automatic test_burst();
    apply_reset();
    req = 4'b0010;
    set_addr(1, 11'h055);
    set_addr(2, 11'h2AA);
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (g[0] !== 4'b0010) begin
        failures++;
        $display("FAIL burst_lock c=%0d: got g=%b expected 0010", c, g[0]);
      end
      if (c == 2) req[2] = 1'b1;
    end
    tick();
    checks++;
    if (g[0] !== 4'b0100 || ma[0] !== 11'h2AA) begin
      failures++;
      $display("FAIL burst_handover: got g=%b ma=%h expected 0100 2aa", g[0], ma[0]);
    end
    req[2] = 1'b0;
    for (int c = 9; c < 21; c++) begin
      tick();
      checks++;
      if (g[0] !== 4'b0010) begin
        failures++;
        $display("FAIL burst_lone c=%0d: got g=%b expected 0010", c, g[0]);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req = 4'b0100;
    set_addr(2, 11'h0A0);
    tick();
    checks++;
    if (g[2] !== 4'b0100) begin
      failures++;
      $display("FAIL mid_pre_grant: got g=%b expected 0100", g[2]);
    end
    req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (g[2] !== 4'b0 || ma[2] !== 11'h0 || dout[2] !== 16'h0 || dv[2] !== 4'b0 ||
        busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got g=%b ma=%h d=%h dv=%b busy=%b expected all zero",
               g[2], ma[2], dout[2], dv[2], busy[2]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (dv[2] !== 4'b0) begin
        failures++;
        $display("FAIL mid_no_valid c=%0d: got dv=%b expected 0000", c, dv[2]);
      end
    end
    req = 4'b1010;
    tick();
    checks++;
    if (g[2] !== 4'b0010) begin
      failures++;
      $display("FAIL mid_first_grant: got g=%b expected 0010", g[2]);
    end
    req = '0;
  endtask

  task automatic test_idle_drop();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (g[0] !== 4'b0 || busy[0] !== 1'b0) begin
        failures++;
        $display("FAIL idle c=%0d: got g=%b busy=%b expected 0000 0", c, g[0], busy[0]);
      end
    end
    req = 4'b0111;
    set_addr(2, 11'h333);
    tick();
    checks++;
    if (g[0] !== 4'b0001) begin
      failures++;
      $display("FAIL drop_first: got g=%b expected 0001", g[0]);
    end
    req = 4'b0100;
    tick();
    checks++;
    if (g[0] !== 4'b0100 || ma[0] !== 11'h333) begin
      failures++;
      $display("FAIL drop_skip: got g=%b ma=%h expected 0100 333", g[0], ma[0]);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (g[0] !== 4'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle: got g=%b busy=%b expected 0000 0", g[0], busy[0]);
    end
  endtask

  // Random traffic against a small reference arbiter; checks every latency instance.
  task automatic test_latency_sweep();
    localparam int N = 150;
    logic [3:0]  hist_tag  [N];
    logic [10:0] hist_addr [N];
    logic [10:0] m_ma;
    int          m_owner;
    bit          m_ov;
    int          m_burst;
    logic [3:0]  eg;
    logic [3:0]  others;
    logic [3:0]  ev;
    bit          found;
    int          start;
    int          idx;
    apply_reset();
    m_owner = 0;
    m_ov    = 0;
    m_burst = 0;
    m_ma    = '0;
    for (int c = 0; c < N; c++) begin
      req = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) set_addr(k, 11'($urandom_range(0, 2047)));
      others = req;
      others[m_owner] = 1'b0;
      eg = '0;
      if (m_ov && req[m_owner] && (m_burst < 8 || others == 4'b0)) begin
        eg[m_owner] = 1'b1;
        if (m_burst < 8) m_burst++;
      end else begin
        start = m_ov ? (m_owner + 1) % 4 : 0;
        found = 0;
        for (int j = 0; j < 4; j++) begin
          idx = (start + j) % 4;
          if (!found && req[idx]) begin
            found   = 1;
            eg[idx] = 1'b1;
            m_owner = idx;
            m_ov    = 1;
            m_burst = 1;
          end
        end
      end
      for (int k = 0; k < 4; k++) if (eg[k]) m_ma = addr[k*11 +: 11];
      hist_tag[c]  = eg;
      hist_addr[c] = m_ma;
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g[i] !== eg || ma[i] !== m_ma || $countones(g[i]) > 1) begin
          failures++;
          $display("FAIL sweep_grant L%0d c=%0d: got g=%b ma=%h expected %b %h", i + 1, c, g[i],
                   ma[i], eg, m_ma);
        end
        ev = (c >= i + 1) ? hist_tag[c-i-1] : 4'b0;
        checks++;
        if (dv[i] !== ev || $countones(dv[i]) > 1) begin
          failures++;
          $display("FAIL sweep_valid L%0d c=%0d: got dv=%b expected %b", i + 1, c, dv[i], ev);
        end else if (ev != 4'b0 && dout[i] !== mem_word(hist_addr[c-i-1])) begin
          failures++;
          $display("FAIL sweep_data L%0d c=%0d: got d=%h expected %h", i + 1, c, dout[i],
                   mem_word(hist_addr[c-i-1]));
        end
      end
    end
    req = '0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_reset_midflight();
    test_idle_drop();
    test_latency_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
